// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/seq_restoring_divider_sub_cla_n.sv
// N-bit combinational carry adder; used by the divider as a subtractor (a + ~b + 1).
module sub_cla_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cy_in,
  output logic [N-1:0] sum,
  output logic         cy_out
);

  logic [N-1:0] g, p;
  logic [N:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cy_in;
    for (int i = 0; i < N; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum    = p ^ c[N-1:0];
  assign cy_out = c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t_sum;
  logic             t_cy;
  logic             neg;

  assign {a_sh, q_sh} = {a_q[WIDTH-1:0], q_q, 1'b0};

  sub_cla_n #(.N(WIDTH + 1)) u_sub (
    .a      (a_sh),
    .b      (~{1'b0, d_q}),
    .cy_in  (1'b1),
    .sum    (t_sum),
    .cy_out (t_cy)
  );

  // Sign bit of the trial difference; carry-out is its complement while A < 2*D.
  assign neg = t_sum[WIDTH] & ~t_cy;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            a_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        a_d   = neg ? a_sh : t_sum;
        q_d   = {q_sh[WIDTH-1:1], ~neg};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quo_d   = q_d;
          rem_d   = a_d[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: expectations queued at start, checked on done.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero;

  typedef struct {
    logic [7:0] dd, dv, q, r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_err = 0;
  int   bcnt = 0;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: plain integer division, all-ones/dividend on zero divisor.
  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv);
    exp_t x;
    x.dd = dd; x.dv = dv;
    if (dv == 0) begin x.q = 8'hFF; x.r = dd; x.dbz = 1'b1; end
    else begin x.q = dd / dv; x.r = dd % dv; x.dbz = 1'b0; end
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("quotient", {24'd0, quotient}, {24'd0, e.q});
          chk("remainder", {24'd0, remainder}, {24'd0, e.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("busy_cycles", bcnt, e.dbz ? 0 : 8);
          if (!e.dbz) begin
            chk("identity", 32'(quotient) * 32'(e.dv) + 32'(remainder), 32'(e.dd));
            chk("rem_lt_div", {31'd0, remainder < e.dv}, 32'd1);
          end
        end
        bcnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((busy || done) && k < 50) begin @(negedge clk); k++; end
    if (k == 50) chk("idle_wait", {30'd0, busy, done}, 32'd0);
  endtask

  // Drives start for one edge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] dd, input logic [7:0] dv, input bit push);
    wait_idle();
    start = 1'b1; dividend = dd; divisor = dv;
    if (push) sb.push_back(model(dd, dv));
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin @(negedge clk); k++; end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    rst = 1'b0;

    start_op(8'd200, 8'd7, 1'b1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("hold_quotient", {24'd0, quotient}, 32'd28);
    chk("hold_remainder", {24'd0, remainder}, 32'd4);

    start_op(8'd255, 8'd1, 1'b1);  wait_drain();
    start_op(8'd0, 8'd13, 1'b1);   wait_drain();
    start_op(8'd5, 8'd9, 1'b1);    wait_drain();
    start_op(8'd255, 8'd255, 1'b1); wait_drain();

    // Divide by zero: done right after the accepting edge.
    start_op(8'd77, 8'd0, 1'b1);
    chk("dbz_done_latency", {30'd0, busy, done}, 32'd1);
    wait_drain();
    start_op(8'd9, 8'd3, 1'b1);
    chk("dbz_clear_on_accept", {30'd0, busy, div_by_zero}, 32'd2);
    wait_drain();

    // Starts during RUN and DONE must be ignored.
    start_op(8'd100, 8'd10, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("in_done_state", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    chk("ignored_back_idle", {30'd0, busy, done}, 32'd0);
    chk("ignored_quotient", {24'd0, quotient}, 32'd10);
    chk("ignored_drain", sb.size(), 32'd0);

    // Reset mid-run abandons the operation.
    start_op(8'd255, 8'd16, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("midrst_outputs", {16'd0, quotient, remainder}, 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    start_op(8'd255, 8'd16, 1'b1); wait_drain();

    for (int i = 0; i < 2000; i++) begin
      start_op(8'($urandom), 8'($urandom_range(1, 255)), 1'b1);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
